// File: rtl/capt_trig_ctrl_pkg.sv
// Shared definitions for the capture/trigger controller and the command decoder.
// Holds the controller state encoding and the trigger-source select codes.
package capt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREFILL  = 3'd1,
    ST_ARMED    = 3'd2,
    ST_POSTTRIG = 3'd3,
    ST_DONE     = 3'd4
  } capt_state_t;

  localparam logic [1:0] TRIG_SRC_UART  = 2'b00;
  localparam logic [1:0] TRIG_SRC_SPI   = 2'b01;
  localparam logic [1:0] TRIG_SRC_EXT   = 2'b10;
  localparam logic [1:0] TRIG_SRC_FORCE = 2'b11;

endpackage

// File: rtl/capt_trig_ctrl_if.sv
// Control/status bundle between the command logic (master) and capt_trig_ctrl (slave).
// Optional CAPT_AUTO_TRIG_EN adds the sticky auto_trig status flag.
interface capt_trig_ctrl_if #(
  parameter int unsigned ADDR_W = 9
);
  logic              UARTtrig;
  logic              SPItrig;
  logic              ext_trig;
  logic [1:0]        trig_src;
  logic              arm;
  logic              ack;
  logic              smpl_en;
  logic [ADDR_W-1:0] trig_pos;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] trig_addr;
  logic              armed;
  logic              triggered;
  logic              capt_done;
`ifdef CAPT_AUTO_TRIG_EN
  logic              auto_trig;

  modport master (
    output UARTtrig, SPItrig, ext_trig, trig_src, arm, ack, smpl_en, trig_pos,
    input  we, waddr, trig_addr, armed, triggered, capt_done, auto_trig
  );
  modport slave (
    input  UARTtrig, SPItrig, ext_trig, trig_src, arm, ack, smpl_en, trig_pos,
    output we, waddr, trig_addr, armed, triggered, capt_done, auto_trig
  );
`else
  modport master (
    output UARTtrig, SPItrig, ext_trig, trig_src, arm, ack, smpl_en, trig_pos,
    input  we, waddr, trig_addr, armed, triggered, capt_done
  );
  modport slave (
    input  UARTtrig, SPItrig, ext_trig, trig_src, arm, ack, smpl_en, trig_pos,
    output we, waddr, trig_addr, armed, triggered, capt_done
  );
`endif
endinterface

// File: rtl/capt_trig_ctrl_sync_edge_det.sv
// Two-flop synchronizer for an asynchronous input followed by a rising-edge pulse.
// rise is high for one clk when the synchronized copy goes 0 -> 1.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic s1_q, s2_q, s3_q;
  logic s1_d, s2_d, s3_d;

  // shift the async input through the synchronizer and the edge-history flop
  always_comb begin
    s1_d = d;
    s2_d = s1_q;
    s3_d = s2_q;
  end

  // synchronizer and history registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/capt_trig_ctrl.sv
// Capture/trigger controller: drives the circular sample RAM write port, enforces
// pre-trigger fill, qualifies the selected trigger source and counts post-trigger
// samples. Optional macro CAPT_AUTO_TRIG_EN adds an ARMED-state timeout that forces
// a trigger and raises the sticky auto_trig flag.
module capt_trig_ctrl
  import capt_pkg::*;
#(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned TO_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  capt_trig_ctrl_if.slave    bus
);
  capt_state_t       state_q, state_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-1:0] trig_addr_q, trig_addr_d;
  logic [ADDR_W-1:0] trig_pos_q, trig_pos_d;
  logic [ADDR_W-1:0] post_cnt_q, post_cnt_d;
  logic [ADDR_W:0]   fill_cnt_q, fill_cnt_d;
  logic [ADDR_W:0]   fill_target;
  logic              ext_rise;
  logic              src_hit;
  logic              trig_take;
  logic              wr;
`ifdef CAPT_AUTO_TRIG_EN
  logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
  logic              auto_trig_q, auto_trig_d;
  logic              auto_fire;
`endif

  sync_edge_det u_ext_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (bus.ext_trig),
    .rise (ext_rise)
  );

  // pre-trigger fill length is DEPTH - trig_pos (DEPTH writes when trig_pos = 0)
  assign fill_target = {1'b1, {ADDR_W{1'b0}}} - {1'b0, trig_pos_q};

  // select the live trigger source
  always_comb begin
    src_hit = 1'b0;
    case (bus.trig_src)
      TRIG_SRC_UART:  src_hit = bus.UARTtrig;
      TRIG_SRC_SPI:   src_hit = bus.SPItrig;
      TRIG_SRC_EXT:   src_hit = ext_rise;
      TRIG_SRC_FORCE: src_hit = 1'b1;
      default:        src_hit = 1'b0;
    endcase
  end

`ifdef CAPT_AUTO_TRIG_EN
  assign auto_fire = (to_cnt_q == '1);
  assign trig_take = src_hit | auto_fire;
`else
  assign trig_take = src_hit;
`endif

  // RAM write strobe; POSTTRIG with trig_pos = 0 takes no post samples
  always_comb begin
    wr = 1'b0;
    case (state_q)
      ST_PREFILL, ST_ARMED: wr = bus.smpl_en;
      ST_POSTTRIG:          wr = bus.smpl_en & (trig_pos_q != '0);
      default:              wr = 1'b0;
    endcase
  end

  // next-state, address and counter logic
  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    trig_addr_d = trig_addr_q;
    trig_pos_d  = trig_pos_q;
    post_cnt_d  = post_cnt_q;
    fill_cnt_d  = fill_cnt_q;
`ifdef CAPT_AUTO_TRIG_EN
    to_cnt_d    = to_cnt_q;
    auto_trig_d = auto_trig_q;
`endif
    if (wr) waddr_d = waddr_q + 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (bus.arm) begin
          state_d    = ST_PREFILL;
          trig_pos_d = bus.trig_pos;
          waddr_d    = '0;
          fill_cnt_d = '0;
`ifdef CAPT_AUTO_TRIG_EN
          auto_trig_d = 1'b0;
`endif
        end
      end
      ST_PREFILL: begin
        if (wr) begin
          fill_cnt_d = fill_cnt_q + 1'b1;
          if (fill_cnt_q + 1'b1 == fill_target) begin
            state_d = ST_ARMED;
`ifdef CAPT_AUTO_TRIG_EN
            to_cnt_d = '0;
`endif
          end
        end
      end
      ST_ARMED: begin
        if (trig_take) begin
          // a coincident sample is still written and lands at trig_addr
          state_d     = ST_POSTTRIG;
          trig_addr_d = waddr_q;
          post_cnt_d  = '0;
`ifdef CAPT_AUTO_TRIG_EN
          if (auto_fire) auto_trig_d = 1'b1;
`endif
        end
`ifdef CAPT_AUTO_TRIG_EN
        else if (bus.smpl_en) begin
          to_cnt_d = to_cnt_q + 1'b1;
        end
`endif
      end
      ST_POSTTRIG: begin
        if (trig_pos_q == '0) begin
          state_d = ST_DONE;
        end else if (wr) begin
          post_cnt_d = post_cnt_q + 1'b1;
          if (post_cnt_q + 1'b1 == trig_pos_q) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (bus.ack) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      waddr_q     <= '0;
      trig_addr_q <= '0;
      trig_pos_q  <= '0;
      post_cnt_q  <= '0;
      fill_cnt_q  <= '0;
`ifdef CAPT_AUTO_TRIG_EN
      to_cnt_q    <= '0;
      auto_trig_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      trig_addr_q <= trig_addr_d;
      trig_pos_q  <= trig_pos_d;
      post_cnt_q  <= post_cnt_d;
      fill_cnt_q  <= fill_cnt_d;
`ifdef CAPT_AUTO_TRIG_EN
      to_cnt_q    <= to_cnt_d;
      auto_trig_q <= auto_trig_d;
`endif
    end
  end

  assign bus.we        = wr;
  assign bus.waddr     = waddr_q;
  assign bus.trig_addr = trig_addr_q;
  assign bus.armed     = (state_q == ST_ARMED);
  assign bus.triggered = (state_q == ST_POSTTRIG) || (state_q == ST_DONE);
  assign bus.capt_done = (state_q == ST_DONE);
`ifdef CAPT_AUTO_TRIG_EN
  assign bus.auto_trig = auto_trig_q;
`endif

endmodule

// File: tb/tb_capt_trig_ctrl.sv
// Directed bench for capt_trig_ctrl with ADDR_W=4 (depth 16).
module tb_capt_trig_ctrl;
  import capt_pkg::*;

  localparam int unsigned AW = 4;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  capt_trig_ctrl_if #(.ADDR_W(AW)) bus ();

  capt_trig_ctrl #(.ADDR_W(AW), .TO_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst          = 1'b1;
    bus.UARTtrig = 1'b0;
    bus.SPItrig  = 1'b0;
    bus.ext_trig = 1'b0;
    bus.trig_src = TRIG_SRC_UART;
    bus.arm      = 1'b0;
    bus.ack      = 1'b0;
    bus.smpl_en  = 1'b0;
    bus.trig_pos = '0;
    tick();
    tick();
    chk("rst_we",        bus.we,        0);
    chk("rst_waddr",     bus.waddr,     0);
    chk("rst_trig_addr", bus.trig_addr, 0);
    chk("rst_armed",     bus.armed,     0);
    chk("rst_triggered", bus.triggered, 0);
    chk("rst_done",      bus.capt_done, 0);
    rst = 1'b0;
    tick();

    // UART source, trig_pos=4: 12 prefill writes, UART pulse in PREFILL ignored
    bus.trig_pos = 4'd4;
    bus.trig_src = TRIG_SRC_UART;
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    bus.smpl_en = 1'b1;
    #1;
    chk("pf_we", bus.we, 1);
    chk("pf_waddr0", bus.waddr, 0);
    for (int i = 1; i <= 12; i++) begin
      bus.UARTtrig = (i == 3);
      tick();
      if (i == 11) begin
        chk("pf_armed_11", bus.armed, 0);
        chk("pf_waddr_11", bus.waddr, 11);
      end
    end
    bus.UARTtrig = 1'b0;
    chk("pf_armed_12", bus.armed, 1);
    chk("pf_waddr_12", bus.waddr, 12);
    chk("pf_trig_ignored", bus.triggered, 0);

    // run to waddr=5 across the wrap; a second arm in ARMED is ignored
    for (int i = 1; i <= 9; i++) begin
      bus.arm = (i == 2);
      tick();
    end
    bus.arm = 1'b0;
    chk("arm2_armed", bus.armed, 1);
    chk("arm2_waddr", bus.waddr, 5);

    bus.UARTtrig = 1'b1;
    tick();
    bus.UARTtrig = 1'b0;
    chk("u_triggered", bus.triggered, 1);
    chk("u_armed",     bus.armed,     0);
    chk("u_trig_addr", bus.trig_addr, 5);
    chk("u_waddr",     bus.waddr,     6);
    for (int i = 1; i <= 3; i++) tick();
    chk("post3_waddr", bus.waddr, 9);
    chk("post3_done",  bus.capt_done, 0);
    chk("post3_we",    bus.we, 1);
    tick();
    chk("post4_done",  bus.capt_done, 1);
    chk("post4_waddr", bus.waddr, 10);
    chk("done_we",     bus.we, 0);
    for (int i = 1; i <= 3; i++) tick();
    chk("done_frozen", bus.waddr, 10);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;
    chk("ack_done", bus.capt_done, 0);
    chk("ack_trig", bus.triggered, 0);

    // software force, trig_pos=0: 16 prefill writes, no post writes
    bus.trig_pos = 4'd0;
    bus.trig_src = TRIG_SRC_FORCE;
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 15) chk("f_armed_15", bus.armed, 0);
    end
    chk("f_armed_16", bus.armed, 1);
    chk("f_waddr_16", bus.waddr, 0);
    tick();
    chk("f_triggered", bus.triggered, 1);
    chk("f_trig_addr", bus.trig_addr, 0);
    chk("f_waddr",     bus.waddr, 1);
    chk("f_post_we",   bus.we, 0);
    tick();
    chk("f_done",       bus.capt_done, 1);
    chk("f_done_waddr", bus.waddr, 1);
    bus.ack = 1'b1;
    tick();
    bus.ack = 1'b0;

    // external source, trig_pos=2: UART/SPI ignored, triggered 3 clk after ext edge
    bus.trig_pos = 4'd2;
    bus.trig_src = TRIG_SRC_EXT;
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    for (int i = 1; i <= 14; i++) tick();
    chk("e_armed", bus.armed, 1);
    chk("e_waddr", bus.waddr, 14);
    bus.UARTtrig = 1'b1;
    tick();
    bus.UARTtrig = 1'b0;
    bus.SPItrig = 1'b1;
    tick();
    bus.SPItrig = 1'b0;
    chk("e_uspi_armed", bus.armed, 1);
    chk("e_uspi_trig",  bus.triggered, 0);
    bus.ext_trig = 1'b1;
    tick();
    chk("e_trig_1clk", bus.triggered, 0);
    tick();
    chk("e_trig_2clk", bus.triggered, 0);
    tick();
    chk("e_trig_3clk", bus.triggered, 1);
    chk("e_trig_addr", bus.trig_addr, 2);
    chk("e_waddr3",    bus.waddr, 3);

    // asynchronous reset in POSTTRIG
    rst = 1'b1;
    #1;
    chk("ar_we",        bus.we, 0);
    chk("ar_waddr",     bus.waddr, 0);
    chk("ar_trig_addr", bus.trig_addr, 0);
    chk("ar_armed",     bus.armed, 0);
    chk("ar_triggered", bus.triggered, 0);
    chk("ar_done",      bus.capt_done, 0);
    bus.ext_trig = 1'b0;
    tick();
    rst = 1'b0;
    tick();

`ifdef CAPT_AUTO_TRIG_EN
    // timeout with TO_W=4: forced after 15 ARMED strobes
    bus.trig_pos = 4'd4;
    bus.trig_src = TRIG_SRC_UART;
    bus.arm = 1'b1;
    tick();
    bus.arm = 1'b0;
    for (int i = 1; i <= 12; i++) tick();
    chk("at_armed", bus.armed, 1);
    chk("at_flag0", bus.auto_trig, 0);
    for (int i = 1; i <= 15; i++) tick();
    chk("at_wait_trig", bus.triggered, 0);
    tick();
    chk("at_triggered", bus.triggered, 1);
    chk("at_flag1",     bus.auto_trig, 1);
    chk("at_trig_addr", bus.trig_addr, 11);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
